mc_arb: RTL and testbench

- Memory-controller request arbiter on mclock.
- Shares the single memory sequencer between three requesters: display refresh (crt), host bridge (hst, fed by the host request block's hst_arb_* outputs) and drawing engine (de).
- Picks a winner, returns a one-cycle grant, issues one command to the sequencer and tracks data beats until the burst completes.

---
 rtl/mc_arb_if.sv | 53 +++++
 rtl/mc_arb.sv | 144 ++++++++++++++
 tb/tb_mc_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_arb_if.sv
// mc_arb_if: request/grant and command bundle for the memory-controller arbiter.
//   master : requester/sequencer side. Drives the requests, seq_rdy and seq_beat.
//            Receives the grants, the command and the status signals.
//   slave  : arbiter side (mc_arb).
//   Signals: crt_* display refresh, hst_arb_* host bridge, de_* drawing engine,
//            seq_* sequencer handshake, mc_cmd_* issued command, arb_busy/arb_err status.
interface mc_arb_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              crt_req;
  logic [ADDR_W-1:0] crt_addr;
  logic [1:0]        crt_page;
  logic              crt_gnt;
  logic              hst_arb_req;
  logic [ADDR_W-1:0] hst_arb_addr;
  logic              hst_arb_read;
  logic [1:0]        hst_arb_page;
  logic              hst_gnt;
  logic              de_req;
  logic [ADDR_W-1:0] de_addr;
  logic              de_read;
  logic [1:0]        de_page;
  logic              de_gnt;
  logic              seq_rdy;
  logic              seq_beat;
  logic              mc_cmd_vld;
  logic [ADDR_W-1:0] mc_cmd_addr;
  logic              mc_cmd_read;
  logic [1:0]        mc_cmd_page;
  logic [1:0]        mc_cmd_src;
  logic              arb_busy;
  logic              arb_err;

  modport master (
    output crt_req, crt_addr, crt_page,
    output hst_arb_req, hst_arb_addr, hst_arb_read, hst_arb_page,
    output de_req, de_addr, de_read, de_page,
    output seq_rdy, seq_beat,
    input  crt_gnt, hst_gnt, de_gnt,
    input  mc_cmd_vld, mc_cmd_addr, mc_cmd_read, mc_cmd_page, mc_cmd_src,
    input  arb_busy, arb_err
  );

  modport slave (
    input  crt_req, crt_addr, crt_page,
    input  hst_arb_req, hst_arb_addr, hst_arb_read, hst_arb_page,
    input  de_req, de_addr, de_read, de_page,
    input  seq_rdy, seq_beat,
    output crt_gnt, hst_gnt, de_gnt,
    output mc_cmd_vld, mc_cmd_addr, mc_cmd_read, mc_cmd_page, mc_cmd_src,
    output arb_busy, arb_err
  );
endinterface

// File: rtl/mc_arb.sv
// mc_arb: shares the memory sequencer between display refresh (crt), host bridge (hst) and
// drawing engine (de). crt has fixed top priority; hst/de alternate round-robin. The winner
// gets a one-cycle grant together with a one-cycle command pulse. Data beats are then counted
// until the burst completes.
//   mclock  : memory clock
//   reset_n : synchronous active-low reset
//   bus     : mc_arb_if.slave (requests, grants, sequencer handshake, command, status)
// Optional feature: define MC_ARB_WDOG_EN to build a BUSY-state idle watchdog. The watchdog
// aborts a burst after WDOG_MAX cycles without a beat and pulses arb_err. When the macro is
// undefined, arb_err is tied to 0.
module mc_arb #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned WDOG_MAX = 255
) (
  input logic     mclock,
  input logic     reset_n,
  mc_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

  state_e            state;
  logic              rr_ptr;     // 0: host preferred, 1: drawing engine preferred
  logic [2:0]        beat_cnt;
  logic              crt_gnt_q, hst_gnt_q, de_gnt_q, cmd_vld_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              cmd_read_q;
  logic [1:0]        cmd_page_q;
  logic [1:0]        cmd_src_q;
  logic              err_q;

  logic any_req, pick_crt, pick_hst, pick_de;

  always_comb begin
    any_req  = bus.crt_req | bus.hst_arb_req | bus.de_req;
    pick_crt = bus.crt_req;
    pick_hst = !bus.crt_req && bus.hst_arb_req && (!bus.de_req || !rr_ptr);
    pick_de  = !bus.crt_req && bus.de_req && (!bus.hst_arb_req || rr_ptr);
  end

`ifdef MC_ARB_WDOG_EN
  localparam logic [7:0] WdogLimit = 8'(WDOG_MAX);
  localparam logic [7:0] WdogPre   = 8'(WDOG_MAX - 1);
  logic [7:0] wdog_cnt;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_MAX;
`endif

  always_ff @(posedge mclock) begin
    if (!reset_n) begin
      state      <= StIdle;
      rr_ptr     <= 1'b0;
      beat_cnt   <= 3'd0;
      crt_gnt_q  <= 1'b0;
      hst_gnt_q  <= 1'b0;
      de_gnt_q   <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_read_q <= 1'b0;
      cmd_page_q <= 2'd0;
      cmd_src_q  <= 2'd0;
      err_q      <= 1'b0;
`ifdef MC_ARB_WDOG_EN
      wdog_cnt   <= 8'd0;
`endif
    end else begin
      // Grants, command valid and error are single-cycle pulses.
      crt_gnt_q <= 1'b0;
      hst_gnt_q <= 1'b0;
      de_gnt_q  <= 1'b0;
      cmd_vld_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.seq_rdy && any_req) begin
            state     <= StGrant;
            cmd_vld_q <= 1'b1;
            if (pick_crt) begin
              crt_gnt_q  <= 1'b1;
              cmd_addr_q <= bus.crt_addr;
              cmd_read_q <= 1'b1;
              cmd_page_q <= bus.crt_page;
              cmd_src_q  <= 2'd0;
            end else if (pick_hst) begin
              hst_gnt_q  <= 1'b1;
              cmd_addr_q <= bus.hst_arb_addr;
              cmd_read_q <= bus.hst_arb_read;
              cmd_page_q <= bus.hst_arb_page;
              cmd_src_q  <= 2'd1;
              rr_ptr     <= 1'b1;
            end else if (pick_de) begin
              de_gnt_q   <= 1'b1;
              cmd_addr_q <= bus.de_addr;
              cmd_read_q <= bus.de_read;
              cmd_page_q <= bus.de_page;
              cmd_src_q  <= 2'd2;
              rr_ptr     <= 1'b0;
            end
          end
        end
        StGrant: begin
          state    <= StBusy;
          beat_cnt <= {1'b0, cmd_page_q} + 3'd1;
`ifdef MC_ARB_WDOG_EN
          wdog_cnt <= 8'd0;
`endif
        end
        StBusy: begin
`ifdef MC_ARB_WDOG_EN
          if (wdog_cnt == WdogLimit) begin
            state <= StIdle;
          end else if (bus.seq_beat) begin
            wdog_cnt <= 8'd0;
            beat_cnt <= beat_cnt - 3'd1;
            if (beat_cnt == 3'd1) state <= StIdle;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
            err_q    <= (wdog_cnt == WdogPre);
          end
`else
          if (bus.seq_beat) begin
            beat_cnt <= beat_cnt - 3'd1;
            if (beat_cnt == 3'd1) state <= StIdle;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.crt_gnt     = crt_gnt_q;
  assign bus.hst_gnt     = hst_gnt_q;
  assign bus.de_gnt      = de_gnt_q;
  assign bus.mc_cmd_vld  = cmd_vld_q;
  assign bus.mc_cmd_addr = cmd_addr_q;
  assign bus.mc_cmd_read = cmd_read_q;
  assign bus.mc_cmd_page = cmd_page_q;
  assign bus.mc_cmd_src  = cmd_src_q;
  assign bus.arb_busy    = (state != StIdle);
  assign bus.arb_err     = err_q;

endmodule

// File: tb/tb_mc_arb.sv
// tb_mc_arb: directed self-checking bench for mc_arb. WDOG_MAX is set to 8 so that the
// watchdog section is short when MC_ARB_WDOG_EN is defined.
module tb_mc_arb;

  localparam int unsigned AW = 23;

  logic mclock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mc_arb_if #(.ADDR_W(AW)) bus ();

  mc_arb #(.ADDR_W(AW), .WDOG_MAX(8)) dut (
    .mclock (mclock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 mclock = ~mclock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclock);
    #1;
  endtask

  // Observed {crt_gnt, hst_gnt, de_gnt, mc_cmd_vld}.
  function automatic logic [31:0] gnt_vec();
    return {28'd0, bus.crt_gnt, bus.hst_gnt, bus.de_gnt, bus.mc_cmd_vld};
  endfunction

  // Called in the GRANT cycle. seq_beat is held high from GRANT on: the GRANT->BUSY edge
  // must not count it, so a burst of n beats needs n further edges.
  task automatic finish_burst(input string tag, input int beats);
    bus.seq_beat = 1'b1;
    tick();
    check_eq({tag, "_busy_after_grant"}, 32'(bus.arb_busy), 32'd1);
    repeat (beats) tick();
    bus.seq_beat = 1'b0;
    check_eq({tag, "_idle_after_burst"}, 32'(bus.arb_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n          = 1'b0;
    bus.crt_req      = 1'b0;
    bus.crt_addr     = '0;
    bus.crt_page     = 2'd0;
    bus.hst_arb_req  = 1'b0;
    bus.hst_arb_addr = '0;
    bus.hst_arb_read = 1'b0;
    bus.hst_arb_page = 2'd0;
    bus.de_req       = 1'b0;
    bus.de_addr      = '0;
    bus.de_read      = 1'b0;
    bus.de_page      = 2'd0;
    bus.seq_rdy      = 1'b0;
    bus.seq_beat     = 1'b0;
    tick();
    tick();
    check_eq("rst_gnt",  gnt_vec(), 32'h0);
    check_eq("rst_busy", 32'(bus.arb_busy), 32'd0);
    check_eq("rst_addr", 32'(bus.mc_cmd_addr), 32'h0);
    check_eq("rst_src",  32'(bus.mc_cmd_src), 32'd0);
    check_eq("rst_page", 32'(bus.mc_cmd_page), 32'd0);
    check_eq("rst_err",  32'(bus.arb_err), 32'd0);
    reset_n = 1'b1;

    // Single host read burst, 4 beats.
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h12345;
    bus.hst_arb_read = 1'b1;
    bus.hst_arb_page = 2'd3;
    bus.seq_rdy      = 1'b1;
    tick();
    check_eq("t1_gnt",  gnt_vec(), 32'h5);
    check_eq("t1_addr", 32'(bus.mc_cmd_addr), 32'h12345);
    check_eq("t1_page", 32'(bus.mc_cmd_page), 32'd3);
    check_eq("t1_src",  32'(bus.mc_cmd_src), 32'd1);
    check_eq("t1_read", 32'(bus.mc_cmd_read), 32'd1);
    check_eq("t1_busy", 32'(bus.arb_busy), 32'd1);
    bus.hst_arb_req = 1'b0;
    tick();
    check_eq("t1_gnt_drop", gnt_vec(), 32'h0);
    check_eq("t1_err",      32'(bus.arb_err), 32'd0);
    bus.seq_beat = 1'b1;
    repeat (3) tick();
    check_eq("t1_busy_3beats", 32'(bus.arb_busy), 32'd1);
    tick();
    bus.seq_beat = 1'b0;
    check_eq("t1_idle_4beats", 32'(bus.arb_busy), 32'd0);
    check_eq("t1_addr_hold",   32'(bus.mc_cmd_addr), 32'h12345);

    // All three request together after a reset (rr_ptr=0): crt, hst, de.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.crt_req      = 1'b1;
    bus.crt_addr     = 23'h00abc;
    bus.crt_page     = 2'd0;
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h1;
    bus.hst_arb_read = 1'b0;
    bus.hst_arb_page = 2'd0;
    bus.de_req       = 1'b1;
    bus.de_addr      = 23'h2;
    bus.de_read      = 1'b0;
    bus.de_page      = 2'd0;
    tick();
    check_eq("t2_crt_gnt",  gnt_vec(), 32'h9);
    check_eq("t2_crt_src",  32'(bus.mc_cmd_src), 32'd0);
    check_eq("t2_crt_read", 32'(bus.mc_cmd_read), 32'd1);
    check_eq("t2_crt_addr", 32'(bus.mc_cmd_addr), 32'habc);
    bus.crt_req = 1'b0;
    finish_burst("t2_crt", 1);
    tick();
    check_eq("t2_hst_gnt", gnt_vec(), 32'h5);
    check_eq("t2_hst_src", 32'(bus.mc_cmd_src), 32'd1);
    check_eq("t2_hst_addr", 32'(bus.mc_cmd_addr), 32'h1);
    bus.hst_arb_req = 1'b0;
    finish_burst("t2_hst", 1);
    tick();
    check_eq("t2_de_gnt",  gnt_vec(), 32'h3);
    check_eq("t2_de_src",  32'(bus.mc_cmd_src), 32'd2);
    check_eq("t2_de_read", 32'(bus.mc_cmd_read), 32'd0);
    bus.de_req = 1'b0;
    finish_burst("t2_de", 1);

    // hst and de held high: grants alternate, starting with hst.
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_read = 1'b1;
    bus.de_req       = 1'b1;
    bus.de_read      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t3_gnt%0d", i), gnt_vec(), (i % 2 == 0) ? 32'h5 : 32'h3);
      check_eq($sformatf("t3_read%0d", i), 32'(bus.mc_cmd_read),
               (i % 2 == 0) ? 32'd1 : 32'd0);
      finish_burst("t3", 1);
    end
    bus.hst_arb_req = 1'b0;
    bus.de_req      = 1'b0;

    // Pending request held off by seq_rdy=0.
    bus.seq_rdy = 1'b0;
    bus.de_req  = 1'b1;
    bus.de_addr = 23'h7ff;
    bus.de_read = 1'b1;
    bus.de_page = 2'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("t4_hold%0d", i), gnt_vec(), 32'h0);
    end
    bus.seq_rdy = 1'b1;
    tick();
    check_eq("t4_gnt",  gnt_vec(), 32'h3);
    check_eq("t4_addr", 32'(bus.mc_cmd_addr), 32'h7ff);
    check_eq("t4_page", 32'(bus.mc_cmd_page), 32'd1);
    bus.de_req = 1'b0;
    finish_burst("t4", 2);

    // Reset in BUSY with 2 beats left.
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h55;
    bus.hst_arb_read = 1'b0;
    bus.hst_arb_page = 2'd3;
    tick();
    check_eq("t5_gnt", gnt_vec(), 32'h5);
    bus.hst_arb_req = 1'b0;
    tick();
    bus.seq_beat = 1'b1;
    repeat (2) tick();
    bus.seq_beat = 1'b0;
    check_eq("t5_busy_pre", 32'(bus.arb_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("t5_gnt_rst",  gnt_vec(), 32'h0);
    check_eq("t5_busy_rst", 32'(bus.arb_busy), 32'd0);
    check_eq("t5_addr_rst", 32'(bus.mc_cmd_addr), 32'h0);
    check_eq("t5_page_rst", 32'(bus.mc_cmd_page), 32'd0);
    check_eq("t5_src_rst",  32'(bus.mc_cmd_src), 32'd0);
    check_eq("t5_err_rst",  32'(bus.arb_err), 32'd0);
    bus.seq_beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t5_post_busy%0d", i), 32'(bus.arb_busy), 32'd0);
      check_eq($sformatf("t5_post_gnt%0d", i), gnt_vec(), 32'h0);
    end
    bus.seq_beat = 1'b0;

`ifdef MC_ARB_WDOG_EN
    // No beats after a de grant: abort after 8 idle BUSY cycles.
    bus.de_req  = 1'b1;
    bus.de_addr = 23'h33;
    bus.de_page = 2'd1;
    tick();
    check_eq("t6_gnt", gnt_vec(), 32'h3);
    bus.de_req = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("t6_err_low%0d", i), 32'(bus.arb_err), 32'd0);
    end
    tick();
    check_eq("t6_err_pulse", 32'(bus.arb_err), 32'd1);
    check_eq("t6_busy_pulse", 32'(bus.arb_busy), 32'd1);
    tick();
    check_eq("t6_err_after", 32'(bus.arb_err), 32'd0);
    check_eq("t6_idle_after", 32'(bus.arb_busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
